// File: rtl/mem_port_ctrl_pkg.sv
// Types shared by the decode, memory-stage and dmem-port logic.
package pipes;

    typedef enum logic [1:0] {
        MSIZE_B = 2'd0,
        MSIZE_H = 2'd1,
        MSIZE_W = 2'd2
    } msize_t;

    // The unused encoding 2'd3 is treated as a word so it can never slip through unaligned.
    function automatic logic is_misaligned(input msize_t size, input logic [1:0] offset);
        case (size)
            MSIZE_B: return 1'b0;
            MSIZE_H: return offset[0];
            default: return offset != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_ctrl_be_lane.sv
// Big-endian lane logic: extracts/extends a load from a word and merges store data into a word.
module be_lane
    import pipes::*;
(
    input  logic [31:0] rbuf,
    input  logic [1:0]  offset,
    input  msize_t      size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged_word
);

    logic [4:0]  byte_base;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Byte at offset o lives at bit 8*(3-o); 3-o is simply ~o for two bits.
    assign byte_base = {~offset, 3'b000};
    assign byte_val  = rbuf[byte_base +: 8];
    assign half_val  = offset[1] ? rbuf[15:0] : rbuf[31:16];

    always_comb begin
        load_val = rbuf;
        case (size)
            MSIZE_B: load_val = {{24{sign_ext & byte_val[7]}}, byte_val};
            MSIZE_H: load_val = {{16{sign_ext & half_val[15]}}, half_val};
            default: load_val = rbuf;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic hit_b;
            logic hit_h;
            logic hit_w;
            assign hit_b = (size == MSIZE_B) && (offset == LANE);
            assign hit_h = (size == MSIZE_H) && (offset[1] == LANE[1]);
            assign hit_w = (size != MSIZE_B) && (size != MSIZE_H);
            assign merged_word[31-8*gi -: 8] =
                hit_w ? wdata[31-8*gi -: 8] :
                hit_b ? wdata[7:0] :
                hit_h ? (LANE[0] ? wdata[7:0] : wdata[15:8]) :
                        rbuf[31-8*gi -: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_port_ctrl.sv
// Memory-stage initiator for the word-wide dmem port: sized loads/stores with
// read-modify-write for sub-word stores and a valid/ready response.
module mem_port_ctrl
    import pipes::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  msize_t      req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_RESP} state_t;

    state_t      state_reg, state_next;
    logic        write_reg, signed_reg, err_reg;
    msize_t      size_reg;
    logic [31:0] addr_reg, wdata_reg, rbuf_reg;

    logic        fire;
    logic        req_err;
    logic [31:0] req_addr_eff;
    logic [31:0] load_val, merged_word;

    assign fire    = req_valid && req_ready;
    assign req_err = ALIGN_CHECK && is_misaligned(req_size, req_addr[1:0]);

    // Without alignment checking the offending low bits are simply dropped.
    always_comb begin
        req_addr_eff = req_addr;
        if (!ALIGN_CHECK) begin
            case (req_size)
                MSIZE_B: req_addr_eff = req_addr;
                MSIZE_H: req_addr_eff[0] = 1'b0;
                default: req_addr_eff[1:0] = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (fire) begin
                    if (req_err)                                 state_next = ST_RESP;
                    else if (!req_write)                         state_next = ST_RD;
                    else if (req_size == MSIZE_B || req_size == MSIZE_H) state_next = ST_RD;
                    else                                         state_next = ST_WR;
                end
            end
            ST_RD:   state_next = write_reg ? ST_WR : ST_RESP;
            ST_WR:   state_next = ST_RESP;
            ST_RESP: if (resp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_reg  <= 1'b0;
            signed_reg <= 1'b0;
            err_reg    <= 1'b0;
            size_reg   <= MSIZE_B;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            rbuf_reg   <= '0;
        end else begin
            if (fire) begin
                write_reg  <= req_write;
                signed_reg <= req_signed;
                err_reg    <= req_err;
                size_reg   <= req_size;
                addr_reg   <= req_addr_eff;
                wdata_reg  <= req_wdata;
            end
            if (state_reg == ST_RD) rbuf_reg <= mem_rdata;
        end
    end

    be_lane u_be_lane (
        .rbuf        (rbuf_reg),
        .offset      (addr_reg[1:0]),
        .size        (size_reg),
        .sign_ext    (signed_reg),
        .wdata       (wdata_reg),
        .load_val    (load_val),
        .merged_word (merged_word)
    );

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_err   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_reg)
            ST_IDLE: req_ready = !reset;
            ST_RD:   mem_addr  = {addr_reg[31:2], 2'b00};
            ST_WR: begin
                // Gating with reset lets a reset in the write cycle cancel the store.
                mem_we    = !reset;
                mem_addr  = {addr_reg[31:2], 2'b00};
                mem_wdata = merged_word;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_reg;
                resp_data  = (err_reg || write_reg) ? 32'h0 : load_val;
            end
            default: ;
        endcase
    end

endmodule
